// File: rtl/qr_column_loader.sv
// qr_column_loader: pops column-major elements from an FWFT fifo, packs ROWS of
// them into one column and offers it downstream with a valid/ready handshake.
// Ports: clk, reset (sync, active-low); fifo_empty/fifo_data in, fifo_rd out;
// col_ready in; col_valid, col_data, col_idx, col_last, col_zero, busy out.
// Optional: define QR_LOADER_ZERO_DETECT_EN to build the all-zero column flag.
module qr_column_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]                  fifo_data,
  output logic                                   fifo_rd,
  input  logic                                   col_ready,
  output logic                                   col_valid,
  output logic [ROWS*DATA_WIDTH-1:0]             col_data,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] col_idx,
  output logic                                   col_last,
  output logic                                   col_zero,
  output logic                                   busy
);

  localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [IW-1:0] COL_LAST = IW'(COLS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [RW-1:0] row_cnt;
  logic          last_pop;
  logic [IW-1:0] idx_nxt;

  // Pops only while filling; reset gates it so nothing is lost during reset.
  assign fifo_rd  = (state == FILL) & ~fifo_empty & reset;
  assign last_pop = fifo_rd & (row_cnt == ROW_LAST);
  assign idx_nxt  = (col_idx == COL_LAST) ? '0 : col_idx + IW'(1);
  assign busy     = (state == HOLD) | (row_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      row_cnt   <= '0;
      col_idx   <= '0;
      col_data  <= '0;
      col_valid <= 1'b0;
      col_last  <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (fifo_rd) begin
            for (int r = 0; r < ROWS; r++) begin
              if (row_cnt == RW'(r))
                col_data[r*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
            end
            row_cnt <= last_pop ? '0 : row_cnt + RW'(1);
          end
          if (last_pop) begin
            state     <= HOLD;
            col_valid <= 1'b1;
            col_last  <= (col_idx == COL_LAST);
          end
        end
        HOLD: begin
          if (col_ready) begin
            state     <= FILL;
            col_valid <= 1'b0;
            col_last  <= 1'b0;
            col_idx   <= idx_nxt;
          end
        end
      endcase
    end
  end

`ifdef QR_LOADER_ZERO_DETECT_EN
  logic zero_acc;
  logic elem_zero;

  assign elem_zero = (fifo_data == '0);

  // zero_acc restarts on the first element of each column; the
  // presented flag folds in the final element at the closing pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      zero_acc <= 1'b0;
      col_zero <= 1'b0;
    end else begin
      if (fifo_rd)
        zero_acc <= (row_cnt == '0) ? elem_zero : (zero_acc & elem_zero);
      if (last_pop)
        col_zero <= zero_acc & elem_zero;
      else if ((state == HOLD) && col_ready)
        col_zero <= 1'b0;
    end
  end
`else
  assign col_zero = 1'b0;
`endif

endmodule

// File: tb/tb_qr_column_loader.sv
// tb_qr_column_loader: directed + random stimulus for qr_column_loader,
// checked against a queue-based model of the fifo and column assembly.
module tb_qr_column_loader;

  localparam int DW   = 32;
  localparam int ROWS = 4;
  localparam int COLS = 2;
  localparam int IW   = 1;

  typedef logic [ROWS*DW-1:0] col_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd;
  logic          col_ready = 1'b0;
  logic          col_valid;
  col_t          col_data;
  logic [IW-1:0] col_idx;
  logic          col_last;
  logic          col_zero;
  logic          busy;

  qr_column_loader #(
    .DATA_WIDTH(DW),
    .ROWS(ROWS),
    .COLS(COLS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .col_ready(col_ready),
    .col_valid(col_valid),
    .col_data(col_data),
    .col_idx(col_idx),
    .col_last(col_last),
    .col_zero(col_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] part[$];
  logic          stall = 1'b0;
  bit            hold = 0;
  col_t          m_data = '0;
  bit            m_zero = 0;
  int            ncol = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input col_t obs, input col_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = stall || (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    q.push_back(v);
    refresh();
  endtask

  task automatic pack();
    bit z;
    m_data = '0;
    z = 1;
    for (int r = 0; r < ROWS; r++) begin
      m_data = m_data | (col_t'(part[r]) << (r * DW));
      if (part[r] != 0) z = 0;
    end
`ifdef QR_LOADER_ZERO_DETECT_EN
    m_zero = z;
`else
    m_zero = 0;
`endif
  endtask

  task automatic cyc();
    bit rd;
    bit hs;
    @(negedge clk);
    rd = reset && !hold && !fifo_empty;
    chk("fifo_rd", col_t'(fifo_rd), col_t'(rd));
    chk("col_valid", col_t'(col_valid), col_t'(hold));
    chk("busy", col_t'(busy), col_t'(hold || part.size() != 0));
    if (hold) begin
      chk("col_data", col_data, m_data);
      chk("col_idx", col_t'(col_idx), col_t'(ncol % COLS));
      chk("col_last", col_t'(col_last), col_t'((ncol % COLS) == COLS - 1));
      chk("col_zero", col_t'(col_zero), col_t'(m_zero));
    end else begin
      chk("col_last_idle", col_t'(col_last), '0);
      chk("col_zero_idle", col_t'(col_zero), '0);
    end
    hs = hold && col_ready;
    @(posedge clk);
    #1;
    if (!reset) begin
      part.delete();
      hold = 0;
      ncol = 0;
    end else if (hs) begin
      hold = 0;
      ncol++;
    end else if (rd) begin
      part.push_back(q.pop_front());
      if (part.size() == ROWS) begin
        pack();
        hold = 1;
        part.delete();
      end
    end
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !hold && part.size() == 0) begin
        done = 1;
        break;
      end
      cyc();
    end
    chk("drain_timeout", col_t'(done), col_t'(1));
  endtask

  initial begin
    bit seen;
    refresh();

    // reset state
    reset = 1'b0;
    run(2);
    chk("reset_data", col_data, '0);
    chk("reset_idx", col_t'(col_idx), '0);
    reset = 1'b1;

    // first column 1..4, literal packing check
    col_ready = 1'b1;
    for (int v = 1; v <= 4; v++) push(v);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (col_valid) begin
        seen = 1;
        break;
      end
      cyc();
    end
    chk("first_col_seen", col_t'(seen), col_t'(1));
    chk("first_col", col_data, 128'h00000004_00000003_00000002_00000001);
    chk("first_idx", col_t'(col_idx), '0);

    // second column (last), then a wrapped column
    for (int v = 5; v <= 12; v++) push(v);
    drain();

    // backpressure in HOLD with fifo still non-empty
    col_ready = 1'b0;
    for (int v = 20; v < 26; v++) push(v);
    run(5);
    run(5);
    col_ready = 1'b1;
    run(3);
    push(26);
    push(27);
    drain();

    // fifo stall after two pops
    for (int v = 30; v < 34; v++) push(v);
    run(2);
    stall = 1'b1;
    refresh();
    run(3);
    stall = 1'b0;
    refresh();
    drain();

    // reset mid-column discards the partial column
    push(100);
    push(101);
    run(2);
    reset = 1'b0;
    run(1);
    chk("midreset_data", col_data, '0);
    chk("midreset_idx", col_t'(col_idx), '0);
    reset = 1'b1;
    for (int v = 9; v <= 12; v++) push(v);
    drain();

    // zero and near-zero columns
    for (int i = 0; i < 4; i++) push(0);
    push(0);
    push(0);
    push(5);
    push(0);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0)
        push(($urandom_range(0, 3) == 0) ? '0 : DW'($urandom));
      col_ready = ($urandom_range(0, 1) == 1);
      stall = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 59) != 0);
      refresh();
      cyc();
    end
    reset = 1'b1;
    stall = 1'b0;
    col_ready = 1'b1;
    refresh();
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
